bless_port_alloc: RTL and testbench

BLESS_PORT_ALLOC -- requirements
Module: bless_port_alloc

---
 rtl/bless_port_alloc.sv | 168 ++++++++++++++++
 tb/tb_bless_port_alloc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bless_port_alloc.sv
`default_nettype none
// ==== bless_port_alloc : BLESS bufferless router port allocator (age-ordered, deflecting)
// ==== Rev 1.0

module bless_port_alloc #(
  parameter int COORD_W    = 3,
  parameter int AGE_W      = 8,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int STARVE_MAX = 16,
  localparam int CW        = 1 + 2*COORD_W + AGE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] ctl0_in,
  input  logic [CW-1:0] ctl1_in,
  input  logic [CW-1:0] ctl2_in,
  input  logic [CW-1:0] ctl3_in,
  input  logic [CW-1:0] inj_ctl,
  input  logic          inj_valid,
  output logic          inj_ack,
  output logic [14:0]   route_config,
  output logic [CW-1:0] ctl0_fwd,
  output logic [CW-1:0] ctl1_fwd,
  output logic [CW-1:0] ctl2_fwd,
  output logic [CW-1:0] ctl3_fwd,
  output logic [CW-1:0] ctl4_fwd,
  output logic          starve
);

  localparam logic [COORD_W-1:0] c_MY_X       = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] c_MY_Y       = COORD_W'(MY_Y);
  localparam logic [AGE_W-1:0]   c_STARVE_MAX = AGE_W'(STARVE_MAX);

  function automatic logic [2:0] f_prod(input logic [CW-1:0] w);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [2:0]         p;
    dx = w[CW-2 -: COORD_W];
    dy = w[AGE_W +: COORD_W];
    if (dx > c_MY_X)      p = 3'd2;
    else if (dx < c_MY_X) p = 3'd3;
    else if (dy > c_MY_Y) p = 3'd1;
    else if (dy < c_MY_Y) p = 3'd0;
    else                  p = 3'd4;
    return p;
  endfunction

  // Productive port if free, else lowest free network port; 3'b111 when none is left.
  function automatic logic [2:0] f_pick(input logic [2:0] prod, input logic [4:0] free);
    logic [2:0] p;
    p = 3'b111;
    if (free[prod]) begin
      p = prod;
    end else begin
      for (int n = 3; n >= 0; n--)
        if (free[n]) p = 3'(n);
    end
    return p;
  endfunction

  function automatic logic [CW-1:0] f_bump(input logic [CW-1:0] w);
    logic [CW-1:0] r;
    r = w;
    if (w[AGE_W-1:0] != '1) r[AGE_W-1:0] = w[AGE_W-1:0] + AGE_W'(1);
    return r;
  endfunction

  logic [CW-1:0]    w_word [5];
  logic [2:0]       w_prod [5];
  logic [AGE_W-1:0] w_age  [5];
  logic [4:0]       w_vld;
  logic [4:0]       w_take;
  logic [CW-1:0]    w_fwd  [5];
  logic [2:0]       w_rank [4];
  logic [4:0]       w_free;
  logic [2:0]       w_port;
  logic [14:0]      w_cfg;
  logic             w_inj_gnt;
  logic             w_clear;

  logic [14:0]      r_cfg;
  logic [CW-1:0]    r_fwd [5];
  logic [AGE_W-1:0] r_cnt;
  logic             r_starve;

  assign w_word[0] = ctl0_in;
  assign w_word[1] = ctl1_in;
  assign w_word[2] = ctl2_in;
  assign w_word[3] = ctl3_in;
  assign w_word[4] = inj_ctl;

  assign w_vld = {inj_valid & inj_ctl[CW-1], ctl3_in[CW-1], ctl2_in[CW-1],
                  ctl1_in[CW-1], ctl0_in[CW-1]};

  for (genvar gi = 0; gi < 5; gi++) begin : g_decode
    assign w_prod[gi] = f_prod(w_word[gi]);
    assign w_age[gi]  = w_word[gi][AGE_W-1:0];
    assign w_fwd[gi]  = w_take[gi] ? f_bump(w_word[gi]) : '0;
  end

  // Rank = number of valid network flits that beat this one; ranks of valid flits are unique.
  always_comb begin
    w_cfg     = '1;
    w_free    = '1;
    w_inj_gnt = 1'b0;
    w_port    = 3'b111;
    for (int i = 0; i < 4; i++) begin
      w_rank[i] = 3'd0;
      for (int j = 0; j < 4; j++)
        if (j != i && w_vld[j] &&
            (w_age[j] > w_age[i] || (w_age[j] == w_age[i] && j < i)))
          w_rank[i] = w_rank[i] + 3'd1;
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (w_vld[i] && w_rank[i] == 3'(k)) begin
          w_port                       = f_pick(w_prod[i], w_free);
          w_free[w_port]               = 1'b0;
          w_cfg[int'(w_port)*3 +: 3]   = 3'(i);
        end
      end
    end
    // Injection only sees what the network flits left behind.
    if (w_vld[4]) begin
      w_port = f_pick(w_prod[4], w_free);
      if (w_port != 3'b111) begin
        w_inj_gnt                  = 1'b1;
        w_free[w_port]             = 1'b0;
        w_cfg[int'(w_port)*3 +: 3] = 3'd4;
      end
    end
  end

  assign w_take  = {w_inj_gnt, w_vld[3:0]};
  assign inj_ack = rst_n & w_inj_gnt;
  assign w_clear = !inj_valid || inj_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg    <= '1;
      r_cnt    <= '0;
      r_starve <= 1'b0;
      for (int n = 0; n < 5; n++) r_fwd[n] <= '0;
    end else begin
      r_cfg <= w_cfg;
      for (int n = 0; n < 5; n++) r_fwd[n] <= w_fwd[n];
      if (w_clear) begin
        r_cnt    <= '0;
        r_starve <= 1'b0;
      end else begin
        r_starve <= (r_cnt == c_STARVE_MAX);
        if (r_cnt != c_STARVE_MAX) r_cnt <= r_cnt + AGE_W'(1);
      end
    end
  end

  assign route_config = r_cfg;
  assign ctl0_fwd     = r_fwd[0];
  assign ctl1_fwd     = r_fwd[1];
  assign ctl2_fwd     = r_fwd[2];
  assign ctl3_fwd     = r_fwd[3];
  assign ctl4_fwd     = r_fwd[4];
  assign starve       = r_starve;

endmodule

`default_nettype wire

// File: tb/tb_bless_port_alloc.sv
`timescale 1ns/1ps
`default_nettype none
// ==== tb_bless_port_alloc : directed + randomized bench with a sort-based allocation model
// ==== Rev 1.0

module tb_bless_port_alloc;

  localparam int COORD_W    = 3;
  localparam int AGE_W      = 8;
  localparam int MY_X       = 0;
  localparam int MY_Y       = 0;
  localparam int STARVE_MAX = 16;
  localparam int CW         = 1 + 2*COORD_W + AGE_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] ctl_in [4];
  logic [CW-1:0] inj_ctl;
  logic          inj_valid;
  logic          inj_ack;
  logic          starve;
  logic [14:0]   route_config;
  logic [CW-1:0] fwd [5];

  int            checks = 0;
  int            errors = 0;
  logic [14:0]   exp_cfg;
  logic [CW-1:0] exp_fwd [5];
  logic          exp_ack;
  logic          exp_starve;
  int            cnt;

  always #5 clk = ~clk;

  bless_port_alloc #(
    .COORD_W(COORD_W), .AGE_W(AGE_W), .MY_X(MY_X), .MY_Y(MY_Y), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ctl0_in(ctl_in[0]), .ctl1_in(ctl_in[1]), .ctl2_in(ctl_in[2]), .ctl3_in(ctl_in[3]),
    .inj_ctl(inj_ctl), .inj_valid(inj_valid), .inj_ack(inj_ack),
    .route_config(route_config),
    .ctl0_fwd(fwd[0]), .ctl1_fwd(fwd[1]), .ctl2_fwd(fwd[2]), .ctl3_fwd(fwd[3]), .ctl4_fwd(fwd[4]),
    .starve(starve)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input int v, input int dx, input int dy, input int age);
    return {1'(v), 3'(dx), 3'(dy), 8'(age)};
  endfunction

  function automatic int dest_port(input logic [CW-1:0] w);
    int dx, dy;
    dx = int'(w[13:11]);
    dy = int'(w[10:8]);
    if (dx > MY_X) return 2;
    if (dx < MY_X) return 3;
    if (dy > MY_Y) return 1;
    if (dy < MY_Y) return 0;
    return 4;
  endfunction

  function automatic int first_free(input bit [4:0] busy);
    for (int n = 0; n < 4; n++) if (!busy[n]) return n;
    return -1;
  endfunction

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] w);
    int a;
    a = int'(w[7:0]) + 1;
    if (a > 255) a = 255;
    return {w[CW-1:8], 8'(a)};
  endfunction

  // Sort valid network flits by key = age*16 + (3-index): older first, lower index on ties.
  task automatic model();
    int     keys[$];
    bit [4:0] busy;
    int     p, i;
    busy    = '0;
    exp_cfg = '1;
    exp_ack = 1'b0;
    for (int n = 0; n < 4; n++)
      if (ctl_in[n][CW-1]) keys.push_back(int'(ctl_in[n][7:0]) * 16 + (3 - n));
    keys.rsort();
    foreach (keys[k]) begin
      i = 3 - (keys[k] % 16);
      p = dest_port(ctl_in[i]);
      if (busy[p]) p = first_free(busy);
      busy[p] = 1'b1;
      exp_cfg[3*p +: 3] = 3'(i);
    end
    if (inj_valid && inj_ctl[CW-1]) begin
      p = dest_port(inj_ctl);
      if (busy[p]) p = first_free(busy);
      if (p >= 0) begin
        exp_ack = 1'b1;
        exp_cfg[3*p +: 3] = 3'd4;
      end
    end
    for (int n = 0; n < 4; n++) exp_fwd[n] = ctl_in[n][CW-1] ? bump(ctl_in[n]) : '0;
    exp_fwd[4] = exp_ack ? bump(inj_ctl) : '0;
  endtask

  task automatic step();
    logic clear;
    model();
    #1;
    chk("inj_ack", 32'(inj_ack), 32'(exp_ack));
    clear = !inj_valid || exp_ack;
    @(posedge clk);
    #1;
    exp_starve = clear ? 1'b0 : (cnt == STARVE_MAX);
    cnt        = clear ? 0 : ((cnt < STARVE_MAX) ? cnt + 1 : cnt);
    chk("route_config", 32'(route_config), 32'(exp_cfg));
    for (int n = 0; n < 5; n++) chk($sformatf("fwd%0d", n), 32'(fwd[n]), 32'(exp_fwd[n]));
    chk("starve", 32'(starve), 32'(exp_starve));
  endtask

  task automatic idle();
    for (int n = 0; n < 4; n++) ctl_in[n] = '0;
    inj_ctl   = '0;
    inj_valid = 1'b0;
  endtask

  function automatic logic [CW-1:0] rnd_word();
    int dx, dy, age;
    dx = ($urandom_range(1, 0) == 1) ? 0 : int'($urandom_range(7, 0));
    dy = ($urandom_range(1, 0) == 1) ? 0 : int'($urandom_range(7, 0));
    case ($urandom_range(3, 0))
      0:       age = int'($urandom_range(3, 0));
      1:       age = int'($urandom_range(255, 254));
      default: age = int'($urandom_range(255, 0));
    endcase
    return mk(($urandom_range(3, 0) != 0) ? 1 : 0, dx, dy, age);
  endfunction

  task automatic rnd_inputs();
    for (int n = 0; n < 4; n++) ctl_in[n] = rnd_word();
    inj_ctl   = rnd_word();
    inj_valid = ($urandom_range(3, 0) != 0);
  endtask

  initial begin
    cnt        = 0;
    exp_starve = 1'b0;
    idle();
    inj_valid  = 1'b1;
    inj_ctl    = mk(1, 1, 0, 3);
    #12;
    chk("rst_cfg", 32'(route_config), 32'h7FFF);
    chk("rst_fwd4", 32'(fwd[4]), 32'h0);
    chk("rst_starve", 32'(starve), 32'h0);
    chk("rst_ack", 32'(inj_ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    idle();
    ctl_in[0] = mk(1, 2, 0, 5);
    step();
    chk("single_cfg", 32'(route_config), 32'h7E3F);
    chk("single_age", 32'(fwd[0][7:0]), 32'd6);

    idle();
    ctl_in[0] = mk(1, 2, 0, 9);
    ctl_in[1] = mk(1, 2, 0, 3);
    step();
    chk("contend_cfg", 32'(route_config), 32'h7E39);
    ctl_in[1] = mk(1, 2, 0, 9);
    step();
    chk("tie_cfg", 32'(route_config), 32'h7E39);

    idle();
    ctl_in[2] = mk(1, 0, 0, 4);
    ctl_in[3] = mk(1, 0, 0, 7);
    step();
    chk("eject_cfg", 32'(route_config), 32'h3FFA);

    idle();
    ctl_in[1] = mk(1, 0, 3, 255);
    step();
    chk("age_sat", 32'(fwd[1][7:0]), 32'd255);

    idle();
    for (int n = 0; n < 4; n++) ctl_in[n] = mk(1, 2, 0, 10 + n);
    inj_valid = 1'b1;
    inj_ctl   = mk(1, 1, 1, 0);
    for (int c = 1; c <= 17; c++) begin
      step();
      chk($sformatf("starve_c%0d", c), 32'(starve), 32'(c >= 17));
    end
    ctl_in[0] = '0;
    step();
    chk("ack_after_drop", 32'(inj_ack), 32'd1);
    chk("starve_drop", 32'(starve), 32'd0);

    for (int it = 0; it < 400; it++) begin
      rnd_inputs();
      step();
    end

    idle();
    inj_valid = 1'b1;
    inj_ctl   = mk(1, 3, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cfg", 32'(route_config), 32'h7FFF);
    chk("arst_fwd0", 32'(fwd[0]), 32'h0);
    chk("arst_starve", 32'(starve), 32'h0);
    chk("arst_ack", 32'(inj_ack), 32'h0);
    cnt        = 0;
    exp_starve = 1'b0;
    #2;
    rst_n = 1'b1;
    rnd_inputs();
    step();
    for (int it = 0; it < 50; it++) begin
      rnd_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
